// File: rtl/load_store_unit.sv
// Load/store unit: turns one-hot Load/Store codes into a single memory
// request/grant/response transaction with byte lanes and load extension.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  Load,
    input  logic [2:0]  Store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_cause,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [4:0]  ld_q;
    logic [1:0]  off_q;

    logic        accept, fail, capture, cnt_hit;
    logic [1:0]  fail_code;
    logic        is_half, is_word, misal;
    logic [3:0]  be_nxt;
    logic [31:0] wd_nxt, load_val, shifted;
    logic [15:0] half_sel;

    assign is_half = Load[1] | Load[4] | Store[1];
    assign is_word = Load[2] | Store[2];
    assign misal   = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
    assign cnt_hit = ((9'(cnt) + 9'd1) == 9'(TIMEOUT));

    always_comb begin
        be_nxt = 4'b0001 << addr[1:0];
        if (is_half) be_nxt = addr[1] ? 4'b1100 : 4'b0011;
        if (is_word) be_nxt = 4'b1111;
        wd_nxt = '0;
        if (Store[0]) wd_nxt = {4{wdata[7:0]}};
        if (Store[1]) wd_nxt = {2{wdata[15:0]}};
        if (Store[2]) wd_nxt = wdata;
    end

    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (ld_q[0])      load_val = {{24{shifted[7]}}, shifted[7:0]};
        else if (ld_q[1]) load_val = {{16{half_sel[15]}}, half_sel};
        else if (ld_q[3]) load_val = {24'h0, shifted[7:0]};
        else if (ld_q[4]) load_val = {16'h0, half_sel};
        else              load_val = mem_rdata;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fail      = 1'b0;
        fail_code = 2'b00;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && (|{Load, Store})) begin
                    if (!$onehot({Load, Store})) begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                        state_nxt = FIN;
                    end else if (misal) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                        state_nxt = FIN;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (cnt_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                    state_nxt = FIN;
                end else if (mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // A response on the timeout cycle still wins over the timeout.
                if (mem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = FIN;
                end else if (cnt_hit) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ld_q      <= '0;
            off_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_cause <= 2'b00;
            rd_data   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state   <= state_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == FIN);
            err     <= fail;
            mem_req <= (state_nxt == REQ);
            if (state == REQ || state == WAIT) cnt <= cnt + 8'd1;
            if (accept) begin
                cnt       <= '0;
                ld_q      <= Load;
                off_q     <= addr[1:0];
                mem_we    <= |Store;
                mem_addr  <= {addr[31:2], 2'b00};
                mem_be    <= be_nxt;
                mem_wdata <= wd_nxt;
            end
            if (fail) err_cause <= fail_code;
            if (capture) begin
                err_cause <= 2'b00;
                if (|ld_q) rd_data <= load_val;
            end
        end
    end

endmodule
